mips_dmem_responder: RTL and testbench
======================================

Name: mips_dmem_responder

Overview:
- Data-memory responder for the single-cycle MIPS core's load/store port.
- Accepts one request at a time over a valid/ready handshake, inserts a fixed number of wait states, and returns a response over a second valid/ready handshake.
- Holds word storage internally, with byte-enable writes and address range/alignment checking.
- Sits between the core's LSU and the data RAM; the core must stall while a request is outstanding.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; power of two, minimum 4.
- WAIT_CYCLES, 2, idle cycles between request accept and response valid; 0 allowed.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables; bit i covers wdata[8i+7:8i]
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  misaligned or out-of-range access
- busy  out  1  request outstanding (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
- Reset does not clear memory contents. Reset mid-transaction abandons the transaction and discards its store (no write occurs).
- Handshake transfer rule: a transfer happens on a rising edge where valid&&ready.
- Payload stability: after a response is presented, rsp_* are held stable until rsp_ready.
- States:
  - IDLE: req_ready=1. On a request transfer, latch we/addr/wdata/be, compute err, then go to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: req_ready=0. The counter runs from WAIT_CYCLES-1 down to 0; at 0, go to RESP.
  - RESP: rsp_valid=1, req_ready=0. On rsp_ready, go to IDLE.
- Latency: rsp_valid rises WAIT_CYCLES+1 edges after the accept edge. With WAIT_CYCLES=0, rsp_valid is high the cycle after accept.
- No back-to-back acceptance: req_ready is low in the RESP cycle, including the cycle in which the response handshakes. Sustained throughput is therefore one transaction per WAIT_CYCLES+2 cycles.
- Error detection:
  - Misaligned: addr[1:0]!=0.
  - Out of range: (addr-BASE_ADDR) >= DEPTH_WORDS*4, computed in 32-bit unsigned arithmetic. Addresses below BASE_ADDR wrap to large values and are flagged.
  - On error: no memory write, rsp_rdata=0, rsp_err=1.
- Store: committed on the edge of entry into RESP, so memory is updated before rsp_valid is observed. Only bytes with be=1 are written. be=0000 is a legal no-op store and returns err=0. rsp_rdata=0.
- Load: word index = (addr-BASE_ADDR)>>2. Data is read on the edge of entry into RESP. The full word is returned regardless of be.
- Memory indexing: the index uses the low log2(DEPTH_WORDS) bits only, with no wrap-around beyond the range check.
- Ignored inputs: req_* are ignored outside IDLE. A core holding req_valid high does not double-issue, because req_ready=0 in those states.
- Simultaneous reset and transfer: rst wins; no state change other than reset.

Decomposition:
- Shared package mips_mem_pkg:
  - state typedef: IDLE, WAIT, RESP.
  - Width constants ADDR_W=32, DATA_W=32, BE_W=4.
  - Error code localparams, for future extension to multi-bit error codes.
- One natural sub-module, mips_dmem_array: synchronous single-port word RAM with byte-enable write and registered read. The responder FSM drives its we, idx, be, wdata.

Test Plan:
- Store then load, WAIT_CYCLES=2:
  - Store addr=4, wdata=15, be=1111 -> rsp_valid at accept+3, err=0, rdata=0.
  - Then load addr=4 -> rdata=15, err=0.
- Byte enables:
  - Store 0xAABBCCDD to addr 8 with be=1111, then store 0x11223344 with be=0101.
  - Load addr 8 -> 0xAA22CC44.
- Errors:
  - Load addr=6 -> err=1, rdata=0.
  - Store addr=256 (DEPTH_WORDS=64) -> err=1.
  - Follow-up load of word 0 is unchanged.
- Response backpressure:
  - Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rdata and err stay stable; req_ready=0 throughout.
  - Release rsp_ready -> IDLE next cycle.
- WAIT_CYCLES=0 with req_valid held high continuously:
  - Accepts occur every 2 cycles when rsp_ready=1.
  - Exactly one response per accept.
- Reset mid-operation:
  - Assert rst during WAIT of a store to addr 12 -> next cycle state is IDLE, rsp_valid=0, req_ready=1.
  - Load addr 12 returns the prior value.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory responder slice.
package mips_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Single-bit today; kept as named codes so a multi-bit error field can grow later.
    localparam logic ERR_NONE   = 1'b0;
    localparam logic ERR_ACCESS = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request fields held while the access is outstanding (the word index is kept separately).
    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic              err;
    } dmem_req_t;

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Load/store request and response handshake between the core LSU and the responder.
import mips_mem_pkg::*;

interface mips_dmem_responder_if;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/mips_dmem_array.sv
// Single-port word RAM with byte-enable write and a registered read port.
// The read register loads on rd_en, clears on rd_clr, and otherwise holds,
// so the response data stays stable while the core back-pressures.
import mips_mem_pkg::*;

module mips_dmem_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (we && be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // Read register: reset and clear force zero, read loads the addressed word.
    always_ff @(posedge clk) begin
        if (rst)         rdata <= '0;
        else if (rd_en)  rdata <= mem[idx];
        else if (rd_clr) rdata <= '0;
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states,
// then a held response. Stores commit and loads read on the edge into RESP.
import mips_mem_pkg::*;

module mips_dmem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  rst,
    mips_dmem_responder_if.slave bus
);

    localparam int                IDX_W = $clog2(DEPTH_WORDS);
    localparam int                CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH_WORDS * 4);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    dmem_req_t         lat;
    logic [IDX_W-1:0]  idx_q;

    logic [ADDR_W-1:0] in_off;
    logic              in_err;
    logic [IDX_W-1:0]  in_idx;
    logic              accept;
    logic              enter_resp;

    logic              cur_we;
    logic              cur_err;
    logic [IDX_W-1:0]  cur_idx;
    logic [DATA_W-1:0] cur_wdata;
    logic [BE_W-1:0]   cur_be;
    logic              ram_we;
    logic              ram_rd;
    logic              ram_clr;
    logic [DATA_W-1:0] ram_rdata;

    // Address decode of the incoming request; below-base addresses wrap high and fail the range test.
    always_comb begin
        in_off = bus.req_addr - BASE_ADDR;
        in_err = (bus.req_addr[1:0] != 2'b00) || (in_off >= SPAN);
        in_idx = in_off[IDX_W+1:2];
    end

    assign accept     = (state == IDLE) && bus.req_valid;
    assign enter_resp = (WAIT_CYCLES == 0) ? accept : ((state == WAIT) && (cnt == '0));

    // RAM controls: with no wait states the access uses the live request, otherwise the latched one.
    always_comb begin
        cur_we    = lat.we;
        cur_err   = lat.err;
        cur_idx   = idx_q;
        cur_wdata = lat.wdata;
        cur_be    = lat.be;
        if (state == IDLE) begin
            cur_we    = bus.req_we;
            cur_err   = in_err;
            cur_idx   = in_idx;
            cur_wdata = bus.req_wdata;
            cur_be    = bus.req_be;
        end
        ram_we  = enter_resp && !rst && cur_we && (cur_err == ERR_NONE);
        ram_rd  = enter_resp && !cur_we && (cur_err == ERR_NONE);
        ram_clr = enter_resp && (cur_we || (cur_err == ERR_ACCESS));
    end

    // Capture the request payload on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat   <= '{we: bus.req_we, wdata: bus.req_wdata, be: bus.req_be, err: in_err};
            idx_q <= in_idx;
        end
    end

    // Handshake FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= ERR_NONE;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    bus.req_ready <= 1'b0;
                    bus.busy      <= 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= in_err;
                    end else begin
                        state <= WAIT;
                        cnt   <= CNT_W'(WAIT_CYCLES - 1);
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= lat.err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= ERR_NONE;
                    bus.req_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mips_dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .rd_en (ram_rd),
        .rd_clr(ram_clr),
        .idx   (cur_idx),
        .be    (cur_be),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    assign bus.rsp_rdata = ram_rdata;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: two instances (2 wait states at base 0,
// 0 wait states at base 0x1000), a per-cycle transaction-level model,
// and directed transactions with literal expectations.
module tb_mips_dmem_responder;

    logic clk;
    logic rst;

    mips_dmem_responder_if if_w2 ();
    mips_dmem_responder_if if_w0 ();

    // Index 0 = WAIT_CYCLES 2 / base 0, index 1 = WAIT_CYCLES 0 / base 0x1000.
    logic [1:0]       d_valid, d_we, d_rrdy;
    logic [1:0][31:0] d_addr, d_wd;
    logic [1:0][3:0]  d_be;
    logic [1:0]       o_rdy, o_rv, o_err, o_busy;
    logic [1:0][31:0] o_rdata;

    assign if_w2.req_valid = d_valid[0];
    assign if_w2.req_we    = d_we[0];
    assign if_w2.req_addr  = d_addr[0];
    assign if_w2.req_wdata = d_wd[0];
    assign if_w2.req_be    = d_be[0];
    assign if_w2.rsp_ready = d_rrdy[0];
    assign if_w0.req_valid = d_valid[1];
    assign if_w0.req_we    = d_we[1];
    assign if_w0.req_addr  = d_addr[1];
    assign if_w0.req_wdata = d_wd[1];
    assign if_w0.req_be    = d_be[1];
    assign if_w0.rsp_ready = d_rrdy[1];
    assign o_rdy   = {if_w0.req_ready, if_w2.req_ready};
    assign o_rv    = {if_w0.rsp_valid, if_w2.rsp_valid};
    assign o_err   = {if_w0.rsp_err,   if_w2.rsp_err};
    assign o_busy  = {if_w0.busy,      if_w2.busy};
    assign o_rdata = {if_w0.rsp_rdata, if_w2.rsp_rdata};

    mips_dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000))
        dut_w2 (.clk(clk), .rst(rst), .bus(if_w2));
    mips_dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000))
        dut_w0 (.clk(clk), .rst(rst), .bus(if_w0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] mm [2][64];
    bit          mk [2][64];
    bit          out    [2];
    int          edges  [2];
    logic        m_we   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    logic [3:0]  m_be   [2];
    logic        x_err  [2];
    logic [31:0] x_rd   [2];
    bit          x_known[2];

    logic             p_rst = 1'b1;
    logic [1:0]       p_qv = '0, p_rr = '0, p_we = '0;
    logic [1:0][31:0] p_addr = '0, p_wd = '0;
    logic [1:0][3:0]  p_be = '0;

    function automatic int w_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 0) ? 32'h0000_0000 : 32'h0000_1000;
    endfunction

    // The access takes effect when the response is due: check address, apply store or fetch load data.
    task automatic commit(input int k);
        logic [31:0] off;
        int          w;
        off        = m_addr[k] - base_of(k);
        x_err[k]   = (m_addr[k] % 4 != 0) || (off >= 32'd256);
        x_rd[k]    = 32'h0;
        x_known[k] = 1'b1;
        if (!x_err[k]) begin
            w = int'(off / 4);
            if (m_we[k]) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[k][b]) mm[k][w][8*b +: 8] = m_wd[k][8*b +: 8];
                if (m_be[k] == 4'hF) mk[k][w] = 1'b1;
            end else begin
                x_rd[k]    = mm[k][w];
                x_known[k] = mk[k][w];
            end
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int W;
            bit exp_rv;
            W = w_of(k);
            if (p_rst) begin
                out[k] = 1'b0;
            end else if (!out[k]) begin
                if (p_qv[k]) begin
                    out[k] = 1'b1; edges[k] = 1;
                    m_we[k] = p_we[k]; m_addr[k] = p_addr[k]; m_wd[k] = p_wd[k]; m_be[k] = p_be[k];
                    if (edges[k] == W + 1) commit(k);
                end
            end else if (edges[k] >= W + 1) begin
                if (p_rr[k]) out[k] = 1'b0;
            end else begin
                edges[k]++;
                if (edges[k] == W + 1) commit(k);
            end
            exp_rv = out[k] && (edges[k] >= W + 1);
            chk($sformatf("req_ready[%0d]", k), o_rdy[k], !out[k]);
            chk($sformatf("busy[%0d]", k), o_busy[k], out[k]);
            chk($sformatf("rsp_valid[%0d]", k), o_rv[k], exp_rv);
            if (exp_rv) begin
                chk($sformatf("rsp_err[%0d]", k), o_err[k], x_err[k]);
                if (x_known[k]) chk($sformatf("rsp_rdata[%0d]", k), o_rdata[k], x_rd[k]);
            end
            if (p_rst) begin
                chk($sformatf("rst_rdata[%0d]", k), o_rdata[k], 32'h0);
                chk($sformatf("rst_err[%0d]", k), o_err[k], 1'b0);
            end
        end
        p_rst = rst; p_qv = d_valid; p_rr = d_rrdy; p_we = d_we;
        p_addr = d_addr; p_wd = d_wd; p_be = d_be;
    endtask

    // Compare process: inputs change just after posedge, so negedge sees settled values.
    initial begin
        for (int k = 0; k < 2; k++) begin
            out[k] = 1'b0; edges[k] = 0;
            for (int i = 0; i < 64; i++) mk[k][i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    // Handshake counters for the throughput test.
    int acc_cnt [2] = '{0, 0};
    int rsp_cnt [2] = '{0, 0};
    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst && d_valid[k] && o_rdy[k]) acc_cnt[k]++;
            if (!rst && o_rv[k] && d_rrdy[k])   rsp_cnt[k]++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic txn(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        d_we[k] = we; d_addr[k] = addr; d_wd[k] = wd; d_be[k] = be; d_valid[k] = 1'b1;
        n = 0;
        while (!o_rdy[k] && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        d_valid[k] = 1'b0;
        lat = 1; n = 0;
        while (!o_rv[k] && n < 100) begin @(posedge clk); #1; lat++; n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL rsp_timeout[%0d]: no rsp_valid within 100 cycles", k);
        end
        repeat (hold) begin @(posedge clk); #1; end
        rd = o_rdata[k]; er = o_err[k];
        d_rrdy[k] = 1'b1;
        @(posedge clk); #1;
        d_rrdy[k] = 1'b0;
    endtask

    task automatic run(input string name, input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input int hold,
                       input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(k, we, addr, wd, be, hold, rd, er, lat);
        chk({name, ".rdata"}, rd, exp_rd);
        chk({name, ".err"}, er, exp_er);
        if (exp_lat > 0) chk({name, ".latency"}, lat, exp_lat);
        chk({name, ".idle_after"}, o_rdy[k], 1'b1);
    endtask

    initial begin
        int a0, r0;
        rst = 1'b1;
        d_valid = '0; d_we = '0; d_rrdy = '0; d_addr = '0; d_wd = '0; d_be = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset.req_ready", o_rdy[0], 1'b1);
        chk("reset.rsp_valid", o_rv[0], 1'b0);

        // WAIT_CYCLES=2: response three edges counting the accept edge.
        run("st_w0",    0, 1, 32'h0,   32'h5A5A_0000, 4'hF, 0, 32'h0, 0, 3);
        run("st_a4",    0, 1, 32'h4,   32'd15,        4'hF, 0, 32'h0, 0, 3);
        run("ld_a4",    0, 0, 32'h4,   32'h0,         4'hF, 0, 32'd15, 0, 3);
        // Byte enables.
        run("st_a8",    0, 1, 32'h8,   32'hAABB_CCDD, 4'hF, 0, 32'h0, 0, 0);
        run("st_a8_be", 0, 1, 32'h8,   32'h1122_3344, 4'h5, 0, 32'h0, 0, 0);
        run("ld_a8",    0, 0, 32'h8,   32'h0,         4'h0, 0, 32'hAA22_CC44, 0, 0);
        // Errors: misaligned, out of range, memory untouched.
        run("ld_mis",   0, 0, 32'h6,   32'h0,         4'hF, 0, 32'h0, 1, 3);
        run("st_oor",   0, 1, 32'h100, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1, 0);
        run("ld_w0",    0, 0, 32'h0,   32'h0,         4'hF, 0, 32'h5A5A_0000, 0, 0);
        // Empty byte-enable store is a legal no-op.
        run("st_be0",   0, 1, 32'h4,   32'hFFFF_FFFF, 4'h0, 0, 32'h0, 0, 0);
        run("ld_a4_b",  0, 0, 32'h4,   32'h0,         4'hF, 0, 32'd15, 0, 0);
        // Backpressure: hold rsp_ready low 5 cycles; the compare process watches stability.
        run("ld_bp",    0, 0, 32'h8,   32'h0,         4'hF, 5, 32'hAA22_CC44, 0, 0);

        // WAIT_CYCLES=0, base 0x1000.
        run("z_st",     1, 1, 32'h1000, 32'h1234_5678, 4'hF, 0, 32'h0, 0, 1);
        run("z_ld",     1, 0, 32'h1000, 32'h0,         4'hF, 0, 32'h1234_5678, 0, 1);
        run("z_st_top", 1, 1, 32'h10FC, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 0, 1);
        run("z_ld_top", 1, 0, 32'h10FC, 32'h0,         4'hF, 0, 32'hCAFE_F00D, 0, 1);
        run("z_below",  1, 0, 32'h0FFC, 32'h0,         4'hF, 0, 32'h0, 1, 1);
        run("z_above",  1, 0, 32'h1100, 32'h0,         4'hF, 0, 32'h0, 1, 1);

        // Continuous req_valid with rsp_ready high: one accept every 2 cycles.
        a0 = acc_cnt[1]; r0 = rsp_cnt[1];
        d_we[1] = 1'b0; d_addr[1] = 32'h1000; d_valid[1] = 1'b1; d_rrdy[1] = 1'b1;
        repeat (10) @(posedge clk);
        #1 d_valid[1] = 1'b0; d_rrdy[1] = 1'b0;
        chk("stream.accepts",   acc_cnt[1] - a0, 32'd5);
        chk("stream.responses", rsp_cnt[1] - r0, 32'd5);

        // Reset during WAIT of a store abandons it.
        run("st_a12",   0, 1, 32'hC,   32'h0C0C_0C0C, 4'hF, 0, 32'h0, 0, 0);
        d_we[0] = 1'b1; d_addr[0] = 32'hC; d_wd[0] = 32'hBAD0_BAD0; d_be[0] = 4'hF; d_valid[0] = 1'b1;
        @(posedge clk); #1 d_valid[0] = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst.rsp_valid", o_rv[0], 1'b0);
        chk("midrst.req_ready", o_rdy[0], 1'b1);
        chk("midrst.busy",      o_busy[0], 1'b0);
        run("ld_a12",   0, 0, 32'hC,   32'h0,         4'hF, 0, 32'h0C0C_0C0C, 0, 3);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
